// File: rtl/fwd_ctrl.sv
// EX-stage operand forwarding selects and load-use stall generation.
// Optional macro FWD_CTRL_STALL_CNT_EN adds a saturating stall_cnt output.
module fwd_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_load,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall,
  output logic              ex_bubble
`ifdef FWD_CTRL_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  if (REG_AW < 1 || CNT_W < 1) begin : g_param_check
    $error("fwd_ctrl: REG_AW and CNT_W must be at least 1");
  end

  // Only the EX {rd, we, load} and MEM {rd, we} slots feed any decision;
  // the WB slot and the MEM load flag would be write-only, so they are not kept.
  logic [REG_AW-1:0] ex_rd, mem_rd;
  logic              ex_we, ex_load, mem_we;
  logic [1:0]        sel_a, sel_b;
  logic              kill;

  function automatic logic hit(input logic [REG_AW-1:0] rs,
                               input logic [REG_AW-1:0] rd,
                               input logic              we);
    return we && (rd == rs) && (rs != '0);
  endfunction

  always_comb begin
    stall = id_valid && !flush && ex_load &&
            (hit(id_rs1, ex_rd, ex_we) || hit(id_rs2, ex_rd, ex_we));
    kill  = flush || stall || !id_valid;

    // Younger producer (EX, moving to MEM) wins over the older one.
    sel_a = 2'b00;
    if (hit(id_rs1, ex_rd, ex_we))       sel_a = 2'b01;
    else if (hit(id_rs1, mem_rd, mem_we)) sel_a = 2'b10;

    sel_b = 2'b00;
    if (hit(id_rs2, ex_rd, ex_we))       sel_b = 2'b01;
    else if (hit(id_rs2, mem_rd, mem_we)) sel_b = 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rd     <= '0;
      ex_we     <= 1'b0;
      ex_load   <= 1'b0;
      mem_rd    <= '0;
      mem_we    <= 1'b0;
      fwd_a     <= 2'b00;
      fwd_b     <= 2'b00;
      ex_bubble <= 1'b1;
    end else if (!hold) begin
      mem_rd <= ex_rd;
      mem_we <= ex_we;
      if (kill) begin
        ex_rd     <= '0;
        ex_we     <= 1'b0;
        ex_load   <= 1'b0;
        fwd_a     <= 2'b00;
        fwd_b     <= 2'b00;
        ex_bubble <= 1'b1;
      end else begin
        ex_rd     <= id_rd;
        ex_we     <= id_we;
        ex_load   <= id_load;
        fwd_a     <= sel_a;
        fwd_b     <= sel_b;
        ex_bubble <= 1'b0;
      end
    end
  end

`ifdef FWD_CTRL_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!hold && stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_ctrl.sv
// Scoreboard bench for fwd_ctrl: directed vectors push expectations, a
// negedge monitor pops and compares them in the cycle they belong to.
module tb_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hold = 1'b0, flush = 1'b0, id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_we = 1'b0, id_load = 1'b0;
  logic [1:0] fwd_a, fwd_b;
  logic       stall, ex_bubble;
`ifdef FWD_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  fwd_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_we(id_we),
    .id_load(id_load), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall),
    .ex_bubble(ex_bubble)
`ifdef FWD_CTRL_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] a;
    logic [1:0] b;
    logic       bub;
    logic       stl;
    int         cnt;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input string fld, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s.%s: got %0d, expected %0d (cycle %0d)", nm, fld, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle that has an expectation is compared at negedge.
  always @(negedge clk) begin
    if (!done) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL %s: expectation for cycle %0d never sampled, now %0d", q[0].nm, q[0].cyc, cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk(e.nm, "fwd_a", int'(fwd_a), int'(e.a));
        chk(e.nm, "fwd_b", int'(fwd_b), int'(e.b));
        chk(e.nm, "ex_bubble", int'(ex_bubble), int'(e.bub));
        chk(e.nm, "stall", int'(stall), int'(e.stl));
`ifdef FWD_CTRL_STALL_CNT_EN
        chk(e.nm, "stall_cnt", int'(stall_cnt), e.cnt);
`endif
      end
    end
  end

  // Drive one cycle's inputs; expectations describe this cycle's outputs
  // (EX contents from the previous edge, stall from the current inputs).
  task automatic vec(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] rd, input logic we, input logic ld,
                     input logic fl, input logic hd,
                     input logic [1:0] ea, input logic [1:0] eb,
                     input logic ebub, input logic estl, input int ecnt,
                     input string nm);
    exp_t e;
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_we = we; id_load = ld; flush = fl; hold = hd;
    e = '{cyc: cyc, a: ea, b: eb, bub: ebub, stl: estl, cnt: ecnt, nm: nm};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    //   v  rs1 rs2 rd  we ld fl hd  a      b      bub stl cnt
    vec(1, 1,  2,  5,  1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, "reset_add_x5");
    vec(1, 5,  6,  10, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, "sub_rs1_x5");
    vec(1, 0,  0,  7,  1, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, "exmem_fwd_a");
    vec(1, 1,  2,  11, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, "unrelated");
    vec(1, 3,  7,  12, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, "reader_x7");
    vec(1, 1,  0,  9,  1, 1, 0, 0, 2'b00, 2'b10, 0, 0, 0, "memwb_fwd_b");
    vec(1, 9,  4,  13, 1, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0, "load_use_stall");
    vec(1, 9,  4,  13, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1, "stall_bubble");
    vec(1, 1,  2,  0,  1, 0, 0, 0, 2'b10, 2'b00, 0, 0, 1, "after_stall_10");
    vec(1, 0,  0,  14, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, "x0_no_stall");
    vec(1, 1,  2,  3,  1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, "x0_not_fwd");
    vec(1, 1,  2,  3,  1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, "x3_writer2");
    vec(1, 3,  3,  15, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, "x3_reader");
    vec(1, 1,  2,  20, 1, 1, 0, 0, 2'b01, 2'b01, 0, 0, 1, "younger_wins");
    vec(1, 20, 0,  16, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 1, "flush_masks_stall");
    vec(1, 20, 5,  17, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1, "flush_bubble");
    vec(1, 17, 0,  21, 1, 1, 0, 0, 2'b10, 2'b00, 0, 0, 1, "post_flush_10");
    for (int i = 0; i < 3; i++)
      vec(1, 21, 0, 18, 1, 0, 0, 1, 2'b01, 2'b00, 0, 1, 1, "hold_freeze");
    vec(1, 21, 0,  18, 1, 0, 0, 0, 2'b01, 2'b00, 0, 1, 1, "hold_release");
    vec(1, 21, 0,  18, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2, "stall_cnt_2");
    vec(1, 0,  0,  22, 1, 0, 0, 0, 2'b10, 2'b00, 0, 0, 2, "pre_reset");

    // Asynchronous reset pulse between edges, sampled while still asserted.
    id_valid = 1'b0; hold = 1'b0; flush = 1'b0;
    rst = 1'b1;
    e = '{cyc: cyc, a: 2'b00, b: 2'b00, bub: 1'b1, stl: 1'b0, cnt: 0, nm: "async_reset"};
    q.push_back(e);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    vec(1, 22, 18, 19, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, "post_reset_idle");
    vec(0, 0,  0,  0,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, "post_reset_sel");

    repeat (2) @(posedge clk);
    #1;
    done = 1'b1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fwd_ctrl.md
Name: fwd_ctrl

Overview:
- Forwarding and hazard controller that generates the 2-bit select codes for the 3:1 32-bit EX-stage operand muxes (mux31 instances on ALU operands A and B).
- Tracks destination-register tags of in-flight instructions through the EX/MEM/WB stages.
- Registers per-operand forward selects as each instruction enters EX.
- Detects load-use hazards and requests a one-cycle stall with bubble insertion.

Parameters:
- REG_AW, 5, register-address width (x0..x31).
- CNT_W, 16, width of the stall counter (used only with the optional feature).

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- hold  input  1  global pipeline freeze (e.g. memory wait); all internal state and outputs hold.
- flush  input  1  taken branch/jump; kill the instruction entering EX.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs1  input  REG_AW  source register 1 of the ID instruction.
- id_rs2  input  REG_AW  source register 2 of the ID instruction.
- id_rd  input  REG_AW  destination register of the ID instruction.
- id_we  input  1  ID instruction writes rd.
- id_load  input  1  ID instruction is a load.
- fwd_a  output  2  select for operand-A mux: 00 = regfile, 01 = EX/MEM result, 10 = MEM/WB result; 11 is never driven.
- fwd_b  output  2  same encoding, operand B.
- stall  output  1  load-use stall request to the PC and IF/ID registers (combinational).
- ex_bubble  output  1  registered; the instruction now in EX is a bubble.

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values:
  - fwd_a = fwd_b = 00; ex_bubble = 1; stall = 0.
  - All tracking registers are cleared: ex/mem/wb rd = 0, we = 0, load = 0.
- Tracking pipeline: three slots (EX, MEM, WB), each holding {rd, we, load}.
  - On each non-hold edge: WB <= MEM, MEM <= EX, and EX <= the ID instruction or a bubble.
  - A bubble is {rd = 0, we = 0, load = 0}.
- Match definition:
  - match(rs, slot) = slot.we & (slot.rd == rs) & (rs != 0).
  - x0 is never forwarded and never stalls.
- Load-use stall:
  - stall = id_valid & ~flush & (match(id_rs1, EX) & EX.load | match(id_rs2, EX) & EX.load).
  - Combinational, same cycle.
- Edge update priority: hold > flush > stall > normal.
  - hold: nothing changes. stall stays a function of the current state.
  - flush: EX <= bubble; ex_bubble <= 1; fwd_a/fwd_b <= 00. MEM/WB still advance.
  - stall: same as flush. The ID instruction is not captured; upstream holds it for one cycle.
  - normal, id_valid = 1:
    - EX <= {id_rd, id_we, id_load}; ex_bubble <= 0.
    - fwd_x <= 01 if match(id_rsx, EX), else 10 if match(id_rsx, MEM), else 00.
    - Comparisons use pre-edge slots: the old EX moves to MEM (01 path) and the old MEM moves to WB (10 path).
  - normal, id_valid = 0: behave as a bubble (same as flush).
- Priority when both slots match: the younger slot wins, so 01 beats 10.
- Latency:
  - Selects are valid for the whole cycle the instruction occupies EX.
  - A load-use hazard costs exactly one stall cycle. After it, the load sits in WB relative to the dependent instruction, which gets select 10.
- Back-to-back loads to the same rd: the stall is evaluated fresh each cycle; no stall persists beyond one cycle per hazard.
- Reset mid-operation clears all slots immediately. The first post-reset instruction gets selects 00.

Optional Feature:
- Macro: FWD_CTRL_STALL_CNT_EN.
- When defined:
  - Adds output port `stall_cnt`, width CNT_W, reset 0.
  - Increments on every non-hold edge where stall = 1.
  - Saturates at all-ones.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then ADD x5 followed by SUB with rs1 = x5 on the next edge -> fwd_a = 01, fwd_b = 00, stall = 0.
- Writer of x7, an unrelated instruction, then a reader with rs2 = x7 -> fwd_b = 10 on the third instruction.
- Load to x9, next instruction reads rs1 = x9:
  - stall = 1 for exactly one cycle and ex_bubble = 1.
  - Then fwd_a = 10.
  - stall_cnt = 1 when FWD_CTRL_STALL_CNT_EN is defined.
- Writer with rd = x0, next reads x0 -> fwd_a = 00, stall = 0. Two writers of x3 back-to-back, then a reader of x3 -> fwd = 01 (younger wins).
- flush asserted together with a load-use hazard -> stall = 0, ex_bubble = 1, fwd = 00. hold asserted for 3 cycles -> fwd, ex_bubble and stall_cnt unchanged.
- rst pulsed asynchronously mid-sequence (between edges) -> outputs return to reset values immediately; the following instruction reading a pre-reset rd gets 00.
